// File: rtl/aibndpnr_bscan_seq.sv
// aibndpnr_bscan_seq: local BSR chain sequencer for one AIB channel.
// Runs reset override, LFSR fill/check through the chain, then apply window.
// Ports: clk/rstb; start/abort control; cfg_* sampled at start accept;
//   jtag_rx_scan_in chain return; jtag_* chain controls (all registered);
//   busy/done/pass/err_cnt status.
module aibndpnr_bscan_seq #(
  parameter int          CHAIN_LEN = 12,
  parameter logic [15:0] SEED_DFLT = 16'hACE1
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  cfg_rst_cyc,
  input  logic [7:0]  cfg_hold_cyc,
  input  logic        cfg_intest,
  input  logic [15:0] cfg_seed,
  input  logic        jtag_rx_scan_in,
  output logic        jtag_clkdr,
  output logic        jtag_scanen,
  output logic        jtag_scan_out,
  output logic        jtag_mode,
  output logic        jtag_intest,
  output logic        jtag_rstb_en,
  output logic        jtag_rstb,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [7:0]  err_cnt
);

  localparam int TW = $clog2(CHAIN_LEN + 1);
  localparam logic [TW-1:0] TLAST = TW'(CHAIN_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RST,
    S_FILL,
    S_CHECK,
    S_APPLY,
    S_DONE
  } st_t;

  st_t          st, nst;
  logic         ph, nph;
  logic [TW-1:0] tk, ntk;
  logic [7:0]   cyc, ncyc;
  logic [7:0]   rst_q, hold_q;
  logic         intest_q;
  logic [15:0]  lfsr, nlfsr;
  logic [15:0]  xlfsr, nxlfsr;
  logic [7:0]   nerr;
  logic         npass;
  logic         accept;
  logic         shifting;
  logic [15:0]  seed_eff;

  function automatic logic [15:0] adv(
    input logic [15:0] l
  );
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  assign seed_eff = (cfg_seed == 16'h0) ? SEED_DFLT
                                        : cfg_seed;

  always_comb begin
    nst    = st;
    nph    = ph;
    ntk    = tk;
    ncyc   = cyc;
    nlfsr  = lfsr;
    nxlfsr = xlfsr;
    nerr   = err_cnt;
    npass  = pass;
    accept = 1'b0;
    unique case (st)
      S_IDLE: begin
        if (start && !abort) begin
          accept = 1'b1;
          nst    = S_LOAD;
          npass  = 1'b0;
          nerr   = 8'h0;
          nlfsr  = seed_eff;
          nxlfsr = seed_eff;
        end
      end
      // One settle cycle: seed and config are in
      // their registers before any chain activity.
      S_LOAD: begin
        nph = 1'b0;
        ntk = TLAST;
        if (rst_q != 8'h0) begin
          nst  = S_RST;
          ncyc = rst_q - 8'd1;
        end else begin
          nst = S_FILL;
        end
      end
      S_RST: begin
        if (cyc == 8'h0) nst = S_FILL;
        else             ncyc = cyc - 8'd1;
      end
      S_FILL: begin
        nph = !ph;
        if (ph) begin
          nlfsr = adv(lfsr);
          if (tk == '0) begin
            nst = S_CHECK;
            ntk = TLAST;
          end else begin
            ntk = tk - 1'b1;
          end
        end
      end
      S_CHECK: begin
        nph = !ph;
        if (!ph) begin
          // End of phase L: chain output is stable.
          nxlfsr = adv(xlfsr);
          if (jtag_rx_scan_in != xlfsr[15] &&
              err_cnt != 8'hFF)
            nerr = err_cnt + 8'd1;
        end else if (tk == '0) begin
          if (hold_q != 8'h0) begin
            nst  = S_APPLY;
            ncyc = hold_q - 8'd1;
          end else begin
            nst   = S_DONE;
            npass = (err_cnt == 8'h0);
          end
        end else begin
          nlfsr = adv(lfsr);
          ntk   = tk - 1'b1;
        end
      end
      S_APPLY: begin
        if (cyc == 8'h0) begin
          nst   = S_DONE;
          npass = (err_cnt == 8'h0);
        end else begin
          ncyc = cyc - 8'd1;
        end
      end
      S_DONE: nst = S_IDLE;
      default: nst = S_IDLE;
    endcase
    if (abort && st != S_IDLE) begin
      nst   = S_IDLE;
      nph   = 1'b0;
      npass = 1'b0;
      nerr  = err_cnt;
    end
  end

  assign shifting = (nst == S_FILL) ||
                    (nst == S_CHECK);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      st            <= S_IDLE;
      ph            <= 1'b0;
      tk            <= '0;
      cyc           <= 8'h0;
      rst_q         <= 8'h0;
      hold_q        <= 8'h0;
      intest_q      <= 1'b0;
      lfsr          <= 16'h0;
      xlfsr         <= 16'h0;
      jtag_clkdr    <= 1'b0;
      jtag_scanen   <= 1'b0;
      jtag_scan_out <= 1'b0;
      jtag_mode     <= 1'b0;
      jtag_intest   <= 1'b0;
      jtag_rstb_en  <= 1'b0;
      jtag_rstb     <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_cnt       <= 8'h0;
    end else begin
      st    <= nst;
      ph    <= nph;
      tk    <= ntk;
      cyc   <= ncyc;
      lfsr  <= nlfsr;
      xlfsr <= nxlfsr;
      if (accept) begin
        rst_q    <= cfg_rst_cyc;
        hold_q   <= cfg_hold_cyc;
        intest_q <= cfg_intest;
      end
      jtag_clkdr    <= shifting && nph;
      jtag_scanen   <= shifting;
      jtag_scan_out <= shifting && nlfsr[15];
      jtag_mode     <= (nst == S_APPLY);
      jtag_intest   <= (nst == S_APPLY) &&
                       intest_q;
      jtag_rstb_en  <= (nst == S_RST);
      jtag_rstb     <= (nst != S_RST);
      busy          <= (nst != S_IDLE);
      done          <= (nst == S_DONE);
      pass          <= npass;
      err_cnt       <= nerr;
    end
  end

endmodule

// File: tb/tb_aibndpnr_bscan_seq.sv
// tb_aibndpnr_bscan_seq: directed bench for the BSR chain sequencer.
// Chain model: posedge-clkdr shift, negedge-clkdr retimed output.
module tb_aibndpnr_bscan_seq;

  logic        clk;
  logic        rstb;
  logic        start;
  logic        abort;
  logic [7:0]  cfg_rst_cyc;
  logic [7:0]  cfg_hold_cyc;
  logic        cfg_intest;
  logic [15:0] cfg_seed;
  logic        rx_in;
  logic        jtag_clkdr;
  logic        jtag_scanen;
  logic        jtag_scan_out;
  logic        jtag_mode;
  logic        jtag_intest;
  logic        jtag_rstb_en;
  logic        jtag_rstb;
  logic        busy;
  logic        done;
  logic        pass;
  logic [7:0]  err_cnt;

  aibndpnr_bscan_seq dut (
    .clk             (clk),
    .rstb            (rstb),
    .start           (start),
    .abort           (abort),
    .cfg_rst_cyc     (cfg_rst_cyc),
    .cfg_hold_cyc    (cfg_hold_cyc),
    .cfg_intest      (cfg_intest),
    .cfg_seed        (cfg_seed),
    .jtag_rx_scan_in (rx_in),
    .jtag_clkdr      (jtag_clkdr),
    .jtag_scanen     (jtag_scanen),
    .jtag_scan_out   (jtag_scan_out),
    .jtag_mode       (jtag_mode),
    .jtag_intest     (jtag_intest),
    .jtag_rstb_en    (jtag_rstb_en),
    .jtag_rstb       (jtag_rstb),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .err_cnt         (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] ch = 16'h0;
  logic        rx_q = 1'b0;
  int          nstg = 12;
  logic        stuck = 1'b0;

  always @(posedge jtag_clkdr)
    ch <= {ch[14:0], jtag_scan_out};
  always @(negedge jtag_clkdr)
    rx_q <= ch[nstg-1];
  assign rx_in = stuck ? 1'b0 : rx_q;

  int   n_rlow = 0, n_ren = 0, n_mode = 0;
  int   n_int = 0, n_cka = 0;
  logic sq[$];

  always @(negedge clk) begin
    if (!jtag_rstb) n_rlow++;
    if (jtag_rstb_en) n_ren++;
    if (jtag_mode) n_mode++;
    if (jtag_intest) n_int++;
    if (jtag_mode && jtag_clkdr) n_cka++;
    if (jtag_clkdr && jtag_scanen)
      sq.push_back(jtag_scan_out);
  end

  int npass = 0, nfail = 0, ntot = 0;
  int b_rlow, b_ren, b_mode, b_int, b_cka, b_sq;
  int lat;
  logic seen;

  task automatic chk(input string tag,
                     input logic [31:0] o,
                     input logic [31:0] e);
    ntot++;
    assert (o === e) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got %0h want %0h",
             tag, o, e);
    end
  endtask

  function automatic logic [11:0] sword();
    logic [11:0] w;
    for (int i = 0; i < 12; i++)
      w[11-i] = (b_sq + i < sq.size()) ?
                sq[b_sq+i] : 1'bx;
    return w;
  endfunction

  task automatic setcfg(input logic [7:0] r,
                        input logic [7:0] h,
                        input logic it,
                        input logic [15:0] sd);
    cfg_rst_cyc  = r;
    cfg_hold_cyc = h;
    cfg_intest   = it;
    cfg_seed     = sd;
  endtask

  task automatic run(input logic [7:0] r,
                     input logic [7:0] h,
                     input logic it,
                     input logic [15:0] sd,
                     input int poke);
    setcfg(r, h, it, sd);
    start  = 1'b1;
    b_rlow = n_rlow;
    b_ren  = n_ren;
    b_mode = n_mode;
    b_int  = n_int;
    b_cka  = n_cka;
    b_sq   = sq.size();
    @(posedge clk); #1;
    start = 1'b0;
    cfg_seed = 16'h5555;
    cfg_rst_cyc = 8'd9;
    lat = -1;
    for (int n = 1; n <= 300; n++) begin
      start = (n == poke);
      @(posedge clk); #1;
      if (done) begin
        lat = n;
        break;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rstb  = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    setcfg(8'd0, 8'd0, 1'b0, 16'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_clkdr", 32'(jtag_clkdr), 0);
    chk("rst_scanen", 32'(jtag_scanen), 0);
    chk("rst_sout", 32'(jtag_scan_out), 0);
    chk("rst_mode", 32'(jtag_mode), 0);
    chk("rst_intest", 32'(jtag_intest), 0);
    chk("rst_ren", 32'(jtag_rstb_en), 0);
    chk("rst_rstb", 32'(jtag_rstb), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pass", 32'(pass), 0);
    chk("rst_err", 32'(err_cnt), 0);
    rstb = 1'b1;
    @(posedge clk); #1;

    // Ideal loopback, seed 1234, R=4 H=3
    run(8'd4, 8'd3, 1'b0, 16'h1234, 0);
    chk("a_lat", lat, 56);
    chk("a_pass", 32'(pass), 1);
    chk("a_err", 32'(err_cnt), 0);
    chk("a_busy", 32'(busy), 1);
    chk("a_rlow", n_rlow - b_rlow, 4);
    chk("a_ren", n_ren - b_ren, 4);
    chk("a_mode", n_mode - b_mode, 3);
    chk("a_int", n_int - b_int, 0);
    chk("a_nbits", sq.size() - b_sq, 24);
    chk("a_bits", 32'(sword()), 32'h123);
    @(posedge clk); #1;
    chk("a_done1", 32'(done), 0);
    chk("a_busy1", 32'(busy), 0);
    chk("a_pass1", 32'(pass), 1);

    // Stuck-at-0 chain, seed FFFF, R=0 H=0
    stuck = 1'b1;
    run(8'd0, 8'd0, 1'b0, 16'hFFFF, 0);
    chk("b_lat", lat, 49);
    chk("b_err", 32'(err_cnt), 12);
    chk("b_pass", 32'(pass), 0);
    chk("b_rlow", n_rlow - b_rlow, 0);
    stuck = 1'b0;
    @(posedge clk); #1;

    // Seed 0 falls back to ACE1
    run(8'd0, 8'd0, 1'b0, 16'h0000, 0);
    chk("c_lat", lat, 49);
    chk("c_bits", 32'(sword()), 32'hACE);
    chk("c_pass", 32'(pass), 1);
    chk("c_err", 32'(err_cnt), 0);
    @(posedge clk); #1;

    // 13-stage chain
    nstg = 13;
    run(8'd0, 8'd0, 1'b0, 16'h1234, 0);
    chk("d_errnz", 32'(err_cnt != 0), 1);
    chk("d_pass", 32'(pass), 0);
    nstg = 12;
    @(posedge clk); #1;

    // Abort in FILL
    setcfg(8'd0, 8'd0, 1'b0, 16'h1234);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("e_ck_pre", 32'(jtag_clkdr), 1);
    chk("e_se_pre", 32'(jtag_scanen), 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("e_busy", 32'(busy), 0);
    chk("e_scanen", 32'(jtag_scanen), 0);
    chk("e_clkdr", 32'(jtag_clkdr), 0);
    chk("e_done", 32'(done), 0);
    chk("e_pass", 32'(pass), 0);
    seen = 1'b0;
    repeat (60) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    chk("e_quiet", 32'(seen), 0);
    run(8'd2, 8'd0, 1'b0, 16'h1234, 0);
    chk("e2_lat", lat, 51);
    chk("e2_pass", 32'(pass), 1);
    @(posedge clk); #1;

    // Abort in CHECK keeps err_cnt
    stuck = 1'b1;
    setcfg(8'd0, 8'd0, 1'b0, 16'hFFFF);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("f_err", 32'(err_cnt), 3);
    chk("f_busy", 32'(busy), 0);
    stuck = 1'b0;
    @(posedge clk); #1;

    // INTEST apply window, start poked inside
    run(8'd4, 8'd5, 1'b1, 16'h1234, 55);
    chk("g_lat", lat, 58);
    chk("g_mode", n_mode - b_mode, 5);
    chk("g_int", n_int - b_int, 5);
    chk("g_cka", n_cka - b_cka, 0);
    chk("g_pass", 32'(pass), 1);
    repeat (3) @(posedge clk);
    #1;
    chk("g_idle", 32'(busy), 0);

    // Async reset mid-sequence
    setcfg(8'd0, 8'd0, 1'b0, 16'h1234);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("h_se_pre", 32'(jtag_scanen), 1);
    #2 rstb = 1'b0;
    #1;
    chk("h_busy", 32'(busy), 0);
    chk("h_scanen", 32'(jtag_scanen), 0);
    chk("h_pass", 32'(pass), 0);
    #3 rstb = 1'b1;
    @(posedge clk); #1;
    chk("h_idle", 32'(busy), 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/aibndpnr_bscan_seq.md
# aibndpnr_bscan_seq

Local boundary-scan sequencer for one AIB channel's JTAG BSR chain (7 TX cells followed by 5 RX cells).
- On a start request it drives the chain's scan-enable, mode, intest, reset-override and CLKDR controls.
- It runs a reset pulse, then an LFSR shift-through integrity test with bit-level compare, then an optional EXTEST/INTEST apply window.
- It sits between the TAP/test-control logic and the per-channel BSR, and replaces hand-sequenced TAP patterns for in-system chain checks.

## Interface
Parameters:
- CHAIN_LEN, 12, number of BSR flops between the chain's scan input and scan output; must be ≥ 2.
- SEED_DFLT, 16'hACE1, LFSR seed substituted when cfg_seed = 0.

Ports:
- clk  in  1  block clock; all state updates on posedge.
- rstb  in  1  reset, asynchronous assert, active low.
- start  in  1  single-cycle request; ignored while busy = 1.
- abort  in  1  synchronous abort; takes priority over everything except rstb.
- cfg_rst_cyc  in  8  reset-override length in cycles; 0 skips the RST state.
- cfg_hold_cyc  in  8  apply-window length in cycles; 0 skips the APPLY state.
- cfg_intest  in  1  1 = APPLY uses INTEST, 0 = EXTEST.
- cfg_seed  in  16  LFSR seed.
- jtag_rx_scan_in  in  1  chain scan output; changes on CLKDR negedge.
- jtag_clkdr  out  1  boundary-scan clock, registered.
- jtag_scanen  out  1  chain shift enable.
- jtag_scan_out  out  1  serial data into the chain.
- jtag_mode  out  1  JTAG mode select.
- jtag_intest  out  1  intest select.
- jtag_rstb_en  out  1  reset override enable.
- jtag_rstb  out  1  override reset value.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse on normal completion.
- pass  out  1  sticky result; cleared on start accept.
- err_cnt  out  8  compare mismatches, saturating at 255.

## Operation
- Config is sampled on the start-accept edge; later config changes have no effect until the next start.
- LFSR: 16-bit Fibonacci, taps 16/14/13/11, shifts left, feedback into bit 0; jtag_scan_out = lfsr[15].
  - A second, expected-value LFSR is loaded with the same seed.
- Tick = 2 cycles: phase L (clkdr = 0), then phase H (clkdr = 1).
  - scan_out and scanen change only at the start of phase L.
  - jtag_rx_scan_in is sampled on the edge that ends phase L.
- States and transitions:
  - IDLE -> RST on start, or -> FILL if cfg_rst_cyc = 0.
  - RST: jtag_rstb_en = 1, jtag_rstb = 0 for cfg_rst_cyc cycles; no clkdr; -> FILL.
  - FILL: scanen = 1, CHAIN_LEN ticks; the TX LFSR advances once per tick; scan-in is not compared; -> CHECK.
  - CHECK: scanen = 1, CHAIN_LEN ticks; the TX LFSR keeps advancing.
    - Each tick, the sampled jtag_rx_scan_in is compared with exp_lfsr[15]; exp_lfsr then advances.
    - A mismatch increments err_cnt (saturating).
    - Exit -> APPLY, or -> DONE if cfg_hold_cyc = 0.
  - APPLY: scanen = 0, clkdr = 0, jtag_mode = 1, jtag_intest = cfg_intest for cfg_hold_cyc cycles; -> DONE.
  - DONE: done = 1 for one cycle; pass = (err_cnt == 0); -> IDLE.
- Bit k shifted in during FILL must be returned during CHECK tick k (chain latency = CHAIN_LEN ticks).
- Tick counter width is clog2(CHAIN_LEN+1); the counter reloads at each state entry.

## Timing
- Reset values: clkdr 0, scanen 0, scan_out 0, mode 0, intest 0, rstb_en 0, jtag_rstb 1, busy 0, done 0, pass 0, err_cnt 0; FSM in IDLE.
- All outputs are registered; there are no combinational input-to-output paths.
- busy = 1 from the cycle after start-accept until the DONE cycle inclusive.
- The done pulse occurs R + 4·CHAIN_LEN + H + 1 cycles after the start-accept edge, where R = cfg_rst_cyc and H = cfg_hold_cyc.
- jtag_mode and jtag_intest deassert on the same edge that leaves APPLY.
- jtag_rstb_en and jtag_rstb release together on the RST exit edge.
- Abort in any non-IDLE state:
  - Next edge: FSM to IDLE, all jtag_* outputs return to reset values, busy = 0.
  - No done pulse; pass = 0; err_cnt holds its value.
- start asserted together with abort is ignored.
- start arriving in the DONE cycle is ignored.
- rstb asserted mid-sequence forces all reset values immediately (asynchronous).

## Test plan
- Ideal loopback model (CHAIN_LEN = 12 flop shift on clkdr), seed 16'h1234, R = 4, H = 3:
  - done at cycle 4+48+3+1 = 56; pass = 1; err_cnt = 0; jtag_rstb low for exactly 4 cycles.
- Model with chain output stuck at 0, seed 16'hFFFF, R = 0, H = 0:
  - err_cnt = 12 (all expected bits 1), pass = 0, done at cycle 49.
- cfg_seed = 0: the serial stream and compare equal those for seed 16'hACE1; pass = 1.
- Chain model with one extra flop (13 stages): err_cnt > 0, pass = 0.
- abort at cycle 20 of FILL:
  - Next cycle busy = 0, scanen = 0, clkdr = 0, no done.
  - A subsequent start completes with pass = 1.
- APPLY with cfg_intest = 1, H = 5:
  - jtag_mode = jtag_intest = 1 for exactly 5 cycles, clkdr stays low throughout.
  - A start pulse during the window is ignored.
